// File: rtl/ps2_scancode_rx_if.sv
// rtl/ps2_scancode_rx_if.sv - PS/2 line inputs and scan-code event outputs
interface ps2_scancode_rx_if;
  logic       ps2clk;
  logic       ps2data;
  logic [7:0] scan_code;
  logic       key_release;
  logic       key_extended;
  logic       scan_valid;
  logic       frame_err;
  logic       busy;

  modport master (
    input  ps2clk, ps2data,
    output scan_code, key_release, key_extended, scan_valid, frame_err, busy
  );

  modport slave (
    output ps2clk, ps2data,
    input  scan_code, key_release, key_extended, scan_valid, frame_err, busy
  );
endinterface

// File: rtl/ps2_scancode_rx.sv
// rtl/ps2_scancode_rx.sv - PS/2 device-to-host receiver with E0/F0 prefix folding
module ps2_scancode_rx #(
  parameter int clk_mhz    = 25,
  parameter int filter_len = 8,
  parameter int timeout_us = 200
) (
  input  logic               clk,
  input  logic               n_reset,
  ps2_scancode_rx_if.master  bus
);

  localparam int tmo_max = clk_mhz * timeout_us;
  localparam int tmo_w   = $clog2(tmo_max + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t                  state, state_nx;
  logic [1:0]              clk_s, dat_s;
  logic [filter_len-1:0]   filt_sr;
  logic                    filt_lvl, filt_prev;
  logic                    fall, data_bit;
  logic [2:0]              bitcnt;
  logic [7:0]              shreg;
  logic                    par_bit;
  logic [tmo_w-1:0]        tmo_cnt;
  logic                    tmo_hit;
  logic                    ext_flag, rel_flag;
  logic                    busy_c, shift_en, par_en, frame_ok, frame_bad;

  // Two-flop synchronisers, then a level filter that only moves on a unanimous window
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      clk_s     <= 2'b11;
      dat_s     <= 2'b11;
      filt_sr   <= '1;
      filt_lvl  <= 1'b1;
      filt_prev <= 1'b1;
    end else begin
      clk_s     <= {clk_s[0], bus.ps2clk};
      dat_s     <= {dat_s[0], bus.ps2data};
      filt_sr   <= {filt_sr[filter_len-2:0], clk_s[1]};
      if (&filt_sr)
        filt_lvl <= 1'b1;
      else if (~|filt_sr)
        filt_lvl <= 1'b0;
      filt_prev <= filt_lvl;
    end
  end

  assign fall     = filt_prev & ~filt_lvl;
  assign data_bit = dat_s[1];
  assign tmo_hit  = (state != IDLE) && (tmo_cnt == tmo_w'(tmo_max));

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (fall) begin
      case (state)
        IDLE:    if (!data_bit) state_nx = DATA;
        DATA:    if (bitcnt == 3'd7) state_nx = PARITY;
        PARITY:  state_nx = STOP;
        STOP:    state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end else if (tmo_hit) begin
      state_nx = IDLE;
    end
  end

  always_comb begin
    busy_c    = (state != IDLE);
    shift_en  = fall && (state == DATA);
    par_en    = fall && (state == PARITY);
    frame_ok  = 1'b0;
    frame_bad = 1'b0;
    if (fall && (state == STOP)) begin
      frame_ok  = data_bit && (^{shreg, par_bit});
      frame_bad = !(data_bit && (^{shreg, par_bit}));
    end else if (!fall && tmo_hit) begin
      frame_bad = 1'b1;
    end
  end

  assign bus.busy = busy_c;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      bitcnt           <= 3'd0;
      shreg            <= 8'h00;
      par_bit          <= 1'b0;
      tmo_cnt          <= '0;
      ext_flag         <= 1'b0;
      rel_flag         <= 1'b0;
      bus.scan_code    <= 8'h00;
      bus.key_release  <= 1'b0;
      bus.key_extended <= 1'b0;
      bus.scan_valid   <= 1'b0;
      bus.frame_err    <= 1'b0;
    end else begin
      bus.scan_valid <= 1'b0;
      bus.frame_err  <= 1'b0;

      if (fall && (state == IDLE))
        bitcnt <= 3'd0;
      else if (shift_en)
        bitcnt <= bitcnt + 3'd1;

      if (shift_en)
        shreg <= {data_bit, shreg[7:1]};
      if (par_en)
        par_bit <= data_bit;

      // Saturating gap counter; only meaningful inside a frame
      if (fall || (state == IDLE))
        tmo_cnt <= '0;
      else if (tmo_cnt != tmo_w'(tmo_max))
        tmo_cnt <= tmo_cnt + tmo_w'(1);

      if (frame_bad) begin
        bus.frame_err <= 1'b1;
        ext_flag      <= 1'b0;
        rel_flag      <= 1'b0;
      end else if (frame_ok) begin
        if (shreg == 8'hE0) begin
          ext_flag <= 1'b1;
        end else if (shreg == 8'hF0) begin
          rel_flag <= 1'b1;
        end else begin
          bus.scan_code    <= shreg;
          bus.key_extended <= ext_flag;
          bus.key_release  <= rel_flag;
          bus.scan_valid   <= 1'b1;
          ext_flag         <= 1'b0;
          rel_flag         <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// tb/tb_ps2_scancode_rx.sv - directed vector bench for ps2_scancode_rx
module tb_ps2_scancode_rx;

  logic clk = 1'b0;
  logic n_reset = 1'b0;
  always #20 clk = ~clk;

  ps2_scancode_rx_if bus ();

  ps2_scancode_rx #(.clk_mhz(25), .filter_len(8), .timeout_us(200)) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (bus)
  );

  typedef struct {
    logic [7:0] b;
    bit         bad_par;
    bit         bad_stop;
    int         exp_sv;
    int         exp_err;
    logic [7:0] exp_code;
    bit         exp_rel;
    bit         exp_ext;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fall_cyc = 0;
  int sv_cnt = 0, err_cnt = 0, sv_cyc = 0, err_cyc = 0;
  logic [7:0] last_code = 8'h00;
  bit last_rel = 0, last_ext = 0, busy_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.busy) busy_seen = 1;
    if (bus.scan_valid) begin
      sv_cnt++;
      sv_cyc    = cyc;
      last_code = bus.scan_code;
      last_rel  = bus.key_release;
      last_ext  = bus.key_extended;
      checks++;
      if (bus.frame_err || bus.busy) begin
        errors++;
        $display("FAIL strobe_exclusive: frame_err=%0b busy=%0b required 0 0", bus.frame_err, bus.busy);
      end
    end
    if (bus.frame_err) begin
      err_cnt++;
      err_cyc = cyc;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [10:0] mk(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    return {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  // Data changes mid-high, bit period 200 clk
  task automatic send_bits(input logic [10:0] frame, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      idle(50);
      bus.ps2data = frame[i];
      idle(50);
      bus.ps2clk = 1'b0;
      fall_cyc = cyc;
      idle(100);
      bus.ps2clk = 1'b1;
    end
    bus.ps2data = 1'b1;
  endtask

  vec_t tbl[12];
  int sv0, e0, d;

  initial begin
    tbl[0]  = '{8'h1C, 0, 0, 1, 0, 8'h1C, 0, 0};
    tbl[1]  = '{8'hF0, 0, 0, 0, 0, 8'h1C, 0, 0};
    tbl[2]  = '{8'h1C, 0, 0, 1, 0, 8'h1C, 1, 0};
    tbl[3]  = '{8'h1C, 0, 0, 1, 0, 8'h1C, 0, 0};
    tbl[4]  = '{8'hE0, 0, 0, 0, 0, 8'h1C, 0, 0};
    tbl[5]  = '{8'hF0, 0, 0, 0, 0, 8'h1C, 0, 0};
    tbl[6]  = '{8'h75, 0, 0, 1, 0, 8'h75, 1, 1};
    tbl[7]  = '{8'h1C, 1, 0, 0, 1, 8'h75, 0, 0};
    tbl[8]  = '{8'h32, 0, 0, 1, 0, 8'h32, 0, 0};
    tbl[9]  = '{8'hF0, 0, 0, 0, 0, 8'h32, 0, 0};
    tbl[10] = '{8'h33, 0, 1, 0, 1, 8'h32, 0, 0};
    tbl[11] = '{8'h1C, 0, 0, 1, 0, 8'h1C, 0, 0};

    bus.ps2clk  = 1'b1;
    bus.ps2data = 1'b1;
    idle(5);
    chk("reset_scan_code", bus.scan_code, 0);
    chk("reset_flags", {bus.key_release, bus.key_extended}, 0);
    chk("reset_strobes", {bus.scan_valid, bus.frame_err}, 0);
    chk("reset_busy", bus.busy, 0);
    n_reset = 1'b1;
    idle(20);

    for (int i = 0; i < 12; i++) begin
      sv0 = sv_cnt;
      e0  = err_cnt;
      send_bits(mk(tbl[i].b, tbl[i].bad_par, tbl[i].bad_stop), 11);
      idle(100);
      chk($sformatf("row%0d_scan_valid_count", i), sv_cnt - sv0, tbl[i].exp_sv);
      chk($sformatf("row%0d_frame_err_count", i), err_cnt - e0, tbl[i].exp_err);
      chk($sformatf("row%0d_scan_code", i), bus.scan_code, tbl[i].exp_code);
      if (tbl[i].exp_sv == 1) begin
        chk($sformatf("row%0d_key_release", i), last_rel, tbl[i].exp_rel);
        chk($sformatf("row%0d_key_extended", i), last_ext, tbl[i].exp_ext);
      end
      if (i == 0)
        chk("latency_stop_edge_to_strobe", sv_cyc - fall_cyc, 12);
    end

    // Short glitch on idle clock line, then a truncated frame left to time out
    busy_seen = 0;
    bus.ps2clk = 1'b0;
    idle(3);
    bus.ps2clk = 1'b1;
    idle(50);
    chk("glitch_busy_seen", busy_seen, 0);
    e0  = err_cnt;
    sv0 = sv_cnt;
    send_bits(mk(8'h5A, 0, 0), 5);
    idle(6500);
    chk("timeout_frame_err_count", err_cnt - e0, 1);
    chk("timeout_no_scan_valid", sv_cnt - sv0, 0);
    chk("timeout_busy", bus.busy, 0);
    d = err_cyc - fall_cyc;
    checks++;
    if (d < 5000 || d > 5020) begin
      errors++;
      $display("FAIL timeout_delay: got %0d clk required 5000..5020", d);
    end
    sv0 = sv_cnt;
    send_bits(mk(8'h5A, 0, 0), 11);
    idle(100);
    chk("after_timeout_scan_valid_count", sv_cnt - sv0, 1);
    chk("after_timeout_scan_code", bus.scan_code, 8'h5A);

    // Prefix lost across a mid-frame reset
    send_bits(mk(8'hE0, 0, 0), 11);
    send_bits(mk(8'h75, 0, 0), 4);
    n_reset = 1'b0;
    idle(2);
    chk("midreset_scan_code", bus.scan_code, 0);
    chk("midreset_flags", {bus.key_release, bus.key_extended}, 0);
    chk("midreset_strobes", {bus.scan_valid, bus.frame_err}, 0);
    chk("midreset_busy", bus.busy, 0);
    n_reset = 1'b1;
    sv0 = sv_cnt;
    e0  = err_cnt;
    idle(200);
    chk("post_reset_no_strobe", (sv_cnt - sv0) + (err_cnt - e0), 0);
    send_bits(mk(8'h75, 0, 0), 11);
    idle(100);
    chk("post_reset_scan_valid_count", sv_cnt - sv0, 1);
    chk("post_reset_scan_code", bus.scan_code, 8'h75);
    chk("post_reset_key_extended", last_ext, 0);
    chk("post_reset_key_release", last_rel, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
